// File: rtl/cp0_core.sv
// -----------------------------------------------------------------------------
// cp0_core -- MIPS-style coprocessor 0 system control block.
//
// Holds the privileged registers (BadVAddr, Count, Compare, Status, Cause, EPC,
// PRId, Config), a prescaled free-running Count with a Compare timer interrupt,
// exception/ERET commit handling and the pipeline interrupt request.
//
// Ports
//   clk          in   1       clock, rising edge
//   rst          in   1       asynchronous active-low reset
//   we_i         in   1       MTC0 write enable
//   waddr_i      in   5       MTC0 register number
//   data_i       in   32      MTC0 write data
//   raddr_i      in   5       MFC0 register number
//   data_o       out  32      MFC0 read data (combinational, registered state)
//   int_i        in   INT_W   level-sensitive hardware interrupt lines
//   exc_valid_i  in   1       exception commit strobe
//   exc_code_i   in   5       ExcCode of the committing exception
//   exc_pc_i     in   32      PC of the faulting instruction
//   exc_bd_i     in   1       faulting instruction sits in a delay slot
//   badvaddr_i   in   32      faulting data address
//   eret_i       in   1       ERET commit strobe
//   status_o     out  32      live Status
//   cause_o      out  32      live Cause
//   epc_o        out  32      live EPC
//   timer_int_o  out  1       sticky Count==Compare flag
//   int_req_o    out  1       interrupt request to the pipeline
// -----------------------------------------------------------------------------
module cp0_core #(
  parameter int          INT_W     = 5,
  parameter int          COUNT_DIV = 2,
  parameter logic [31:0] PRID_VAL  = 32'h004C_0102
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [4:0]       waddr_i,
  input  logic [31:0]      data_i,
  input  logic [4:0]       raddr_i,
  output logic [31:0]      data_o,
  input  logic [INT_W-1:0] int_i,
  input  logic             exc_valid_i,
  input  logic [4:0]       exc_code_i,
  input  logic [31:0]      exc_pc_i,
  input  logic             exc_bd_i,
  input  logic [31:0]      badvaddr_i,
  input  logic             eret_i,
  output logic [31:0]      status_o,
  output logic [31:0]      cause_o,
  output logic [31:0]      epc_o,
  output logic             timer_int_o,
  output logic             int_req_o
);

  localparam logic [4:0]  ADDR_BADVADDR = 5'd8;
  localparam logic [4:0]  ADDR_COUNT    = 5'd9;
  localparam logic [4:0]  ADDR_COMPARE  = 5'd11;
  localparam logic [4:0]  ADDR_STATUS   = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE    = 5'd13;
  localparam logic [4:0]  ADDR_EPC      = 5'd14;
  localparam logic [4:0]  ADDR_PRID     = 5'd15;
  localparam logic [4:0]  ADDR_CONFIG   = 5'd16;
  localparam logic [31:0] CONFIG_VAL    = 32'h0000_8000;
  localparam logic [1:0]  PRESC_MAX     = 2'(COUNT_DIV - 1);

  // Registered state
  logic [1:0]       r_presc;
  logic [31:0]      r_count;
  logic [31:0]      r_compare;
  logic             r_timer_int;
  logic [31:0]      r_badvaddr;
  logic [31:0]      r_epc;
  // Status fields
  logic             r_cu0;
  logic             r_bev;
  logic [7:0]       r_im;
  logic             r_exl;
  logic             r_ie;
  // Cause fields
  logic             r_bd;
  logic             r_iv;
  logic             r_wp;
  logic [1:0]       r_ip_sw;
  logic [INT_W-1:0] r_ip_hw;
  logic [4:0]       r_exc_code;

  // MTC0 decode
  logic w_wr_count;
  logic w_wr_compare;
  logic w_wr_status;
  logic w_wr_cause;
  logic w_wr_epc;
  logic w_timer_match;
  logic w_adel_ades;
  logic w_eret_eff;
  logic [4:0]  w_ip_hw5;
  logic [31:0] w_status;
  logic [31:0] w_cause;

  assign w_wr_count   = we_i && (waddr_i == ADDR_COUNT);
  assign w_wr_compare = we_i && (waddr_i == ADDR_COMPARE);
  assign w_wr_status  = we_i && (waddr_i == ADDR_STATUS);
  assign w_wr_cause   = we_i && (waddr_i == ADDR_CAUSE);
  assign w_wr_epc     = we_i && (waddr_i == ADDR_EPC);

  // Compare==0 disables the timer so a freshly reset core never fires.
  assign w_timer_match = (r_compare != 32'd0) && (r_count == r_compare);
  assign w_adel_ades   = (exc_code_i == 5'd4) || (exc_code_i == 5'd5);
  // An exception committing in the same cycle masks the ERET.
  assign w_eret_eff    = eret_i && !exc_valid_i;

  // Hardware IP lines padded to five bits; lines above INT_W read 0.
  always_comb begin
    w_ip_hw5 = '0;
    w_ip_hw5[INT_W-1:0] = r_ip_hw;
  end

  assign w_status = {3'b000, r_cu0, 5'b00000, r_bev, 6'b000000, r_im,
                     6'b000000, r_exl, r_ie};
  assign w_cause  = {r_bd, 7'b0000000, r_iv, r_wp, 6'b000000,
                     r_timer_int, w_ip_hw5, r_ip_sw, 1'b0, r_exc_code, 2'b00};

  // Count and prescaler. An MTC0 to Count restarts the prescaler phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= 2'd0;
      r_count <= 32'd0;
    end else if (w_wr_count) begin
      r_presc <= 2'd0;
      r_count <= data_i;
    end else if (r_presc == PRESC_MAX) begin
      r_presc <= 2'd0;
      r_count <= r_count + 32'd1;
    end else begin
      r_presc <= r_presc + 2'd1;
    end
  end

  // Compare and sticky timer flag; writing Compare clears the flag even if
  // the match condition holds in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_compare   <= 32'd0;
      r_timer_int <= 1'b0;
    end else if (w_wr_compare) begin
      r_compare   <= data_i;
      r_timer_int <= 1'b0;
    end else if (w_timer_match) begin
      r_timer_int <= 1'b1;
    end
  end

  // Status. EXL is shared by MTC0, exception and ERET; hardware wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cu0 <= 1'b1;
      r_bev <= 1'b0;
      r_im  <= 8'd0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
    end else begin
      if (w_wr_status) begin
        r_cu0 <= data_i[28];
        r_bev <= data_i[22];
        r_im  <= data_i[15:8];
        r_ie  <= data_i[0];
      end
      if (exc_valid_i)      r_exl <= 1'b1;
      else if (w_eret_eff)  r_exl <= 1'b0;
      else if (w_wr_status) r_exl <= data_i[1];
    end
  end

  // Cause, EPC and BadVAddr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bd       <= 1'b0;
      r_iv       <= 1'b0;
      r_wp       <= 1'b0;
      r_ip_sw    <= 2'd0;
      r_ip_hw    <= '0;
      r_exc_code <= 5'd0;
      r_epc      <= 32'd0;
      r_badvaddr <= 32'd0;
    end else begin
      r_ip_hw <= int_i;
      if (w_wr_cause) begin
        r_iv    <= data_i[23];
        r_wp    <= data_i[22];
        r_ip_sw <= data_i[9:8];
      end
      if (exc_valid_i) begin
        r_exc_code <= exc_code_i;
        // A nested exception keeps the original return point.
        if (!r_exl) begin
          r_bd  <= exc_bd_i;
          r_epc <= exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
        end else if (w_wr_epc) begin
          r_epc <= data_i;
        end
        if (w_adel_ades) r_badvaddr <= badvaddr_i;
      end else if (w_wr_epc) begin
        r_epc <= data_i;
      end
    end
  end

  // MFC0 read port, no write bypass.
  always_comb begin
    data_o = 32'd0;
    case (raddr_i)
      ADDR_BADVADDR: data_o = r_badvaddr;
      ADDR_COUNT:    data_o = r_count;
      ADDR_COMPARE:  data_o = r_compare;
      ADDR_STATUS:   data_o = w_status;
      ADDR_CAUSE:    data_o = w_cause;
      ADDR_EPC:      data_o = r_epc;
      ADDR_PRID:     data_o = PRID_VAL;
      ADDR_CONFIG:   data_o = CONFIG_VAL;
      default:       data_o = 32'd0;
    endcase
  end

  assign status_o    = w_status;
  assign cause_o     = w_cause;
  assign epc_o       = r_epc;
  assign timer_int_o = r_timer_int;
  assign int_req_o   = r_ie && !r_exl && (|(r_im & w_cause[15:8]));

endmodule

// File: tb/tb_cp0_core.sv
module tb_cp0_core;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_o;
  logic [4:0]  int_i;
  logic        exc_valid_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        exc_bd_i;
  logic [31:0] badvaddr_i;
  logic        eret_i;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        timer_int_o;
  logic        int_req_o;

  int n_pass;
  int n_total;

  cp0_core #(
    .INT_W(5),
    .COUNT_DIV(2),
    .PRID_VAL(32'h004C_0102)
  ) dut (
    .clk(clk),
    .rst(rst),
    .we_i(we_i),
    .waddr_i(waddr_i),
    .data_i(data_i),
    .raddr_i(raddr_i),
    .data_o(data_o),
    .int_i(int_i),
    .exc_valid_i(exc_valid_i),
    .exc_code_i(exc_code_i),
    .exc_pc_i(exc_pc_i),
    .exc_bd_i(exc_bd_i),
    .badvaddr_i(badvaddr_i),
    .eret_i(eret_i),
    .status_o(status_o),
    .cause_o(cause_o),
    .epc_o(epc_o),
    .timer_int_o(timer_int_o),
    .int_req_o(int_req_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  // Advance one rising edge, then settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    raddr_i = a;
    #1;
    d = data_o;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; data_i = d;
    step();
    we_i = 1'b0;
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc,
                     input logic bd, input logic [31:0] bva);
    exc_valid_i = 1'b1; exc_code_i = code; exc_pc_i = pc;
    exc_bd_i = bd; badvaddr_i = bva;
    step();
    exc_valid_i = 1'b0;
  endtask

  task automatic eret();
    eret_i = 1'b1;
    step();
    eret_i = 1'b0;
  endtask

  logic [31:0] d;

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; we_i = 1'b0; waddr_i = '0; data_i = '0; raddr_i = '0;
    int_i = '0; exc_valid_i = 1'b0; exc_code_i = '0; exc_pc_i = '0;
    exc_bd_i = 1'b0; badvaddr_i = '0; eret_i = 1'b0;

    vecs[0]  = '{1'b1, 5'd12, 32'hFFFF_FFFF, 5'd12, 32'h1040_FF03, "status_mask"};
    vecs[1]  = '{1'b1, 5'd12, 32'h0000_0000, 5'd12, 32'h0000_0000, "status_zero"};
    vecs[2]  = '{1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h00C0_0328, "cause_mask"};
    vecs[3]  = '{1'b1, 5'd13, 32'h0000_0000, 5'd13, 32'h0000_0028, "cause_zero"};
    vecs[4]  = '{1'b1, 5'd14, 32'h1234_5678, 5'd14, 32'h1234_5678, "epc_write"};
    vecs[5]  = '{1'b1, 5'd8,  32'hFFFF_FFFF, 5'd8,  32'h0000_1003, "badvaddr_ro"};
    vecs[6]  = '{1'b1, 5'd15, 32'h0000_0000, 5'd15, 32'h004C_0102, "prid_ro"};
    vecs[7]  = '{1'b1, 5'd16, 32'h0000_0000, 5'd16, 32'h0000_8000, "config_ro"};
    vecs[8]  = '{1'b1, 5'd5,  32'hFFFF_FFFF, 5'd5,  32'h0000_0000, "unmapped"};
    vecs[9]  = '{1'b1, 5'd9,  32'h0000_0100, 5'd9,  32'h0000_0100, "count_write"};
    vecs[10] = '{1'b1, 5'd11, 32'h0000_0055, 5'd11, 32'h0000_0055, "compare_write"};
    vecs[11] = '{1'b0, 5'd0,  32'h0000_0000, 5'd31, 32'h0000_0000, "read_r31"};

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_status", status_o, 32'h1000_0000);
    check("rst_cause", cause_o, 32'h0);
    check("rst_epc", epc_o, 32'h0);
    check("rst_timer", {31'd0, timer_int_o}, 32'h0);
    check("rst_int_req", {31'd0, int_req_o}, 32'h0);
    rd(5'd16, d); check("rst_config", d, 32'h0000_8000);
    rd(5'd9, d);  check("rst_count", d, 32'h0);
    step(); step();
    rst = 1'b1;

    // Count divider
    repeat (10) step();
    rd(5'd9, d); check("div_count10", d, 32'd5);
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, d); check("count_loaded", d, 32'hFFFF_FFFF);
    step(); step();
    rd(5'd9, d); check("count_wrap", d, 32'h0);

    // Timer (Count advances every 2 edges)
    mtc0(5'd12, 32'h1000_8001);
    mtc0(5'd11, 32'd8);
    mtc0(5'd9, 32'd0);
    repeat (16) step();
    rd(5'd9, d); check("timer_count8", d, 32'd8);
    check("timer_not_yet", {31'd0, timer_int_o}, 32'h0);
    step();
    check("timer_set", {31'd0, timer_int_o}, 32'h1);
    check("timer_int_req", {31'd0, int_req_o}, 32'h1);
    check("timer_cause", cause_o, 32'h0000_8000);
    repeat (3) step();
    check("timer_sticky", {31'd0, timer_int_o}, 32'h1);
    mtc0(5'd11, 32'd20);
    check("timer_clr", {31'd0, timer_int_o}, 32'h0);
    check("timer_clr_req", {31'd0, int_req_o}, 32'h0);
    mtc0(5'd9, 32'd20);
    mtc0(5'd11, 32'd20);
    check("clr_beats_match", {31'd0, timer_int_o}, 32'h0);
    step();
    check("match_after_clr", {31'd0, timer_int_o}, 32'h1);
    mtc0(5'd11, 32'd0);

    // Delay-slot exception
    exc(5'h0C, 32'h8000_0104, 1'b1, 32'h0000_DEAD);
    check("ds_epc", epc_o, 32'h8000_0100);
    check("ds_cause", cause_o, 32'h8000_0030);
    check("ds_status", status_o, 32'h1000_8003);
    rd(5'd8, d); check("ds_badvaddr", d, 32'h0);

    // Nested exception
    exc(5'd4, 32'h8000_0200, 1'b0, 32'h0000_1003);
    check("nest_epc", epc_o, 32'h8000_0100);
    check("nest_cause", cause_o, 32'h8000_0010);
    rd(5'd8, d); check("nest_badvaddr", d, 32'h0000_1003);
    eret();
    check("eret_status", status_o, 32'h1000_8001);

    // Collisions
    eret_i = 1'b1;
    exc(5'h08, 32'h8000_0300, 1'b0, 32'h0);
    eret_i = 1'b0;
    check("col_eret_status", status_o, 32'h1000_8003);
    check("col_eret_epc", epc_o, 32'h8000_0300);
    eret();
    we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0;
    exc(5'h0A, 32'h8000_0400, 1'b0, 32'h0);
    we_i = 1'b0;
    check("col_mtc0_status", status_o, 32'h0000_0002);
    check("col_mtc0_cause", cause_o, 32'h0000_0028);
    eret();

    // Interrupt masking
    int_i = 5'b00001;
    mtc0(5'd12, 32'h0000_0401);
    check("irq_cause", cause_o, 32'h0000_0428);
    check("irq_req", {31'd0, int_req_o}, 32'h1);
    mtc0(5'd12, 32'h0000_0400);
    check("irq_ie_off", {31'd0, int_req_o}, 32'h0);
    mtc0(5'd12, 32'h0000_0403);
    check("irq_exl_mask", {31'd0, int_req_o}, 32'h0);
    int_i = 5'b00000;
    mtc0(5'd12, 32'h0);

    // Register write/read table
    for (int i = 0; i < 12; i++) begin
      we_i = vecs[i].we; waddr_i = vecs[i].waddr; data_i = vecs[i].wdata;
      step();
      we_i = 1'b0;
      rd(vecs[i].raddr, d);
      check(vecs[i].name, d, vecs[i].exp);
    end

    // No same-cycle write bypass on the read port
    we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h0000_AAAA;
    rd(5'd14, d); check("no_bypass", d, 32'h1234_5678);
    step();
    we_i = 1'b0;
    rd(5'd14, d); check("epc_after", d, 32'h0000_AAAA);

    // Reset mid-operation abandons a pending exception update
    exc_valid_i = 1'b1; exc_code_i = 5'd4; badvaddr_i = 32'h0000_BEEF;
    exc_pc_i = 32'h8000_0500; exc_bd_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_status", status_o, 32'h1000_0000);
    check("mid_rst_epc", epc_o, 32'h0);
    exc_valid_i = 1'b0;
    step();
    rst = 1'b1;
    step(); step();
    rd(5'd8, d); check("mid_rst_badvaddr", d, 32'h0);
    rd(5'd9, d); check("post_rst_count", d, 32'd1);
    check("post_rst_status", status_o, 32'h1000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
